// File: rtl/bnn_pkg.sv
// Shared types and elaboration-time helpers for the BNN layer sequencer.
package bnn_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} seq_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Never returns 0 so single-entry ranges still get a 1-bit field.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bnn_wrap_counter.sv
// Up-counter with runtime wrap limit; wrap_o flags the enabled step at the limit.
module bnn_wrap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);
  logic [W-1:0] count_q, count_d;

  assign wrap_o  = en_i && (count_q == limit_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = wrap_o ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/bnn_layer_sequencer.sv
// Walks beats/neuron-groups/layers of a BNN, with per-layer drain gaps.
// Optional cycle counter enabled by defining BNN_LAYER_SEQ_PERF_EN.
module bnn_layer_sequencer
  import bnn_pkg::*;
#(
  parameter int LAYERS                   = 3,
  parameter int PARALLEL_INPUTS          = 8,
  parameter int PARALLEL_NEURONS [LAYERS] = '{default: 8},
  parameter int LAYER_INPUTS [LAYERS]     = '{default: 64},
  parameter int LAYER_NEURONS [LAYERS]    = '{default: 64},
  parameter int ADDR_WIDTH               = 16,
  parameter int PIPE_LAT                 = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            cfg_loaded,
  input  logic                            datapath_ready,
  output logic                            busy,
  output logic                            done,
  output logic [safe_clog2(LAYERS)-1:0]   layer_sel,
  output logic                            weight_rd_en,
  output logic [ADDR_WIDTH-1:0]           weight_rd_addr,
  output logic                            threshold_rd_en,
  output logic [ADDR_WIDTH-1:0]           threshold_rd_addr,
  output logic                            beat_first,
  output logic                            beat_last,
  output logic [31:0]                     perf_cycles
);
  localparam int LW = safe_clog2(LAYERS);
  localparam int DW = safe_clog2(PIPE_LAT);

  seq_state_e            state_q, state_d;
  logic [LW-1:0]         layer_q, layer_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic [ADDR_WIDTH-1:0] beats_lim, grps_lim, beat_cnt, grp_cnt;
  logic                  run, ctr_clr, beat_wrap, grp_wrap;

  // Per-layer geometry is constant; this is a mux over elaborated values.
  always_comb begin
    beats_lim = '0;
    grps_lim  = '0;
    for (int l = 0; l < LAYERS; l++) begin
      if (layer_q == LW'(l)) begin
        beats_lim = ADDR_WIDTH'(ceil_div(LAYER_INPUTS[l], PARALLEL_INPUTS));
        grps_lim  = ADDR_WIDTH'(ceil_div(LAYER_NEURONS[l], PARALLEL_NEURONS[l]));
      end
    end
  end

  assign run     = (state_q == S_RUN);
  assign ctr_clr = !run || abort;

  bnn_wrap_counter #(.W(ADDR_WIDTH)) u_beat (
    .clk(clk), .rst(rst), .en_i(weight_rd_en), .clr_i(ctr_clr),
    .limit_i(beats_lim - 1'b1), .count_o(beat_cnt), .wrap_o(beat_wrap)
  );

  bnn_wrap_counter #(.W(ADDR_WIDTH)) u_grp (
    .clk(clk), .rst(rst), .en_i(beat_wrap), .clr_i(ctr_clr),
    .limit_i(grps_lim - 1'b1), .count_o(grp_cnt), .wrap_o(grp_wrap)
  );

  assign weight_rd_en      = run && datapath_ready;
  assign weight_rd_addr    = grp_cnt * beats_lim + beat_cnt;
  assign beat_first        = weight_rd_en && (beat_cnt == '0);
  assign beat_last         = beat_wrap;
  assign threshold_rd_en   = beat_wrap;
  assign threshold_rd_addr = grp_cnt;
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign layer_sel         = layer_q;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    drain_d = '0;
    if (abort) begin
      state_d = S_IDLE;
      layer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start && cfg_loaded) begin
          state_d = S_RUN;
          layer_d = '0;
        end
        S_RUN: if (grp_wrap) state_d = S_DRAIN;
        S_DRAIN: begin
          if (drain_q == DW'(PIPE_LAT - 1)) begin
            if (layer_q == LW'(LAYERS - 1)) state_d = S_DONE;
            else begin
              state_d = S_RUN;
              layer_d = layer_q + 1'b1;
            end
          end else drain_d = drain_q + 1'b1;
        end
        S_DONE: begin
          state_d = S_IDLE;
          layer_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      drain_q <= drain_d;
    end
  end

`ifdef BNN_LAYER_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && start && cfg_loaded && !abort) perf_d = '0;
    else if (busy && perf_q != '1)                          perf_d = perf_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed + random bench for bnn_layer_sequencer against a beat-plan queue model.
module tb_bnn_layer_sequencer;
  localparam int LAYERS   = 2;
  localparam int PI       = 8;
  localparam int PIPE_LAT = 4;
  localparam int AW       = 16;
  localparam int LIN [LAYERS] = '{16, 8};
  localparam int LNE [LAYERS] = '{8, 4};
  localparam int PN  [LAYERS] = '{4, 4};

  logic          clk, rst, start, abort, cfg_loaded, datapath_ready;
  logic          busy, done, weight_rd_en, threshold_rd_en, beat_first, beat_last;
  logic [0:0]    layer_sel;
  logic [AW-1:0] weight_rd_addr, threshold_rd_addr;
  logic [31:0]   perf_cycles;

  bnn_layer_sequencer #(
    .LAYERS(LAYERS), .PARALLEL_INPUTS(PI), .PARALLEL_NEURONS(PN),
    .LAYER_INPUTS(LIN), .LAYER_NEURONS(LNE), .ADDR_WIDTH(AW), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_loaded(cfg_loaded),
    .datapath_ready(datapath_ready), .busy(busy), .done(done), .layer_sel(layer_sel),
    .weight_rd_en(weight_rd_en), .weight_rd_addr(weight_rd_addr),
    .threshold_rd_en(threshold_rd_en), .threshold_rd_addr(threshold_rd_addr),
    .beat_first(beat_first), .beat_last(beat_last), .perf_cycles(perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an inference is a list of per-cycle items (beat / drain / done).
  localparam int K_BEAT = 0, K_DRAIN = 1, K_DONE = 2;
  typedef struct {int kind; int layer; int addr; int grp; bit first; bit last;} item_t;

  item_t       plan[$];
  int unsigned perf_m;
  int          cyc, done_cyc, n_chk, n_pass, n_fail;

  task automatic build_plan();
    item_t it;
    plan.delete();
    for (int l = 0; l < LAYERS; l++) begin
      int beats, groups;
      beats  = (LIN[l] + PI - 1) / PI;
      groups = (LNE[l] + PN[l] - 1) / PN[l];
      for (int g = 0; g < groups; g++)
        for (int b = 0; b < beats; b++) begin
          it = '{K_BEAT, l, g * beats + b, g, b == 0, b == beats - 1};
          plan.push_back(it);
        end
      for (int d = 0; d < PIPE_LAT; d++) begin
        it = '{K_DRAIN, l, 0, 0, 1'b0, 1'b0};
        plan.push_back(it);
      end
    end
    it = '{K_DONE, LAYERS - 1, 0, 0, 1'b0, 1'b0};
    plan.push_back(it);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit ab, input bit cfg, input bit rdy);
    logic        e_busy, e_done, e_wen, e_ten, e_first, e_last;
    int          e_layer, e_addr, e_taddr;
    logic [38:0] e, o;
    logic [31:0] e_perf;
    item_t       h;
    rst = r; start = st; abort = ab; cfg_loaded = cfg; datapath_ready = rdy;
    {e_busy, e_done, e_wen, e_ten, e_first, e_last} = '0;
    e_layer = 0; e_addr = 0; e_taddr = 0;
    if (plan.size() != 0) begin
      h = plan[0];
      e_busy  = 1'b1;
      e_layer = h.layer;
      e_done  = (h.kind == K_DONE);
      if (h.kind == K_BEAT) begin
        e_wen   = rdy;
        e_addr  = h.addr;
        e_taddr = h.grp;
        e_first = rdy && h.first;
        e_last  = rdy && h.last;
        e_ten   = rdy && h.last;
      end
    end
    e = {e_busy, e_done, 1'(e_layer), e_wen, AW'(e_addr), e_ten, AW'(e_taddr), e_first, e_last};
`ifdef BNN_LAYER_SEQ_PERF_EN
    e_perf = perf_m;
`else
    e_perf = '0;
`endif
    @(negedge clk);
    o = {busy, done, layer_sel, weight_rd_en, weight_rd_addr, threshold_rd_en,
         threshold_rd_addr, beat_first, beat_last};
    chk("outputs", o, e);
    chk("perf", perf_cycles, e_perf);
    if (done && done_cyc < 0) done_cyc = cyc;
    if (r) begin
      plan.delete();
      perf_m = 0;
    end else begin
      if (plan.size() != 0 && perf_m != 32'hFFFF_FFFF) perf_m++;
      if (ab) plan.delete();
      else if (plan.size() == 0) begin
        if (st && cfg) begin
          build_plan();
          perf_m = 0;
        end
      end else if (plan[0].kind != K_BEAT || rdy) void'(plan.pop_front());
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; perf_m = 0; cyc = 0; done_cyc = -1;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_loaded = 1'b0; datapath_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 1, 1);

    // Nominal run, full ready.
    cyc = 0; done_cyc = -1;
    step(0, 1, 0, 1, 1);
    for (int i = 1; i <= 20; i++) step(0, 0, 0, 1, 1);
    chk("done_nominal", done_cyc, 14);
`ifdef BNN_LAYER_SEQ_PERF_EN
    chk("perf_nominal", perf_cycles, 14);
`else
    chk("perf_nominal", perf_cycles, 0);
`endif

    // Backpressure on cycles 2-3.
    cyc = 0; done_cyc = -1;
    step(0, 1, 0, 1, 1);
    for (int i = 1; i <= 22; i++) step(0, 0, 0, 1, !(i == 2 || i == 3));
    chk("done_stall", done_cyc, 16);

    // Start without config is dropped; start mid-run is dropped.
    cyc = 0; done_cyc = -1;
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("cfg_gate_busy", busy, 0);
    cyc = 0; done_cyc = -1;
    step(0, 1, 0, 1, 1);
    for (int i = 1; i <= 20; i++) step(0, i == 6, 0, 1, 1);
    chk("done_restart_ignored", done_cyc, 14);

    // Abort at 3, restart at 5.
    cyc = 0; done_cyc = -1;
    step(0, 1, 0, 1, 1);
    for (int i = 1; i <= 25; i++) step(0, i == 5, i == 3, 1, 1);
    chk("done_after_abort", done_cyc, 19);

    // Reset mid-inference.
    cyc = 0; done_cyc = -1;
    step(0, 1, 0, 1, 1);
    for (int i = 1; i <= 18; i++) step(i == 10, 0, 0, 1, 1);
    chk("no_done_after_rst", done_cyc, -1);

    for (int i = 0; i < 900; i++)
      step($urandom % 200 == 0, $urandom % 8 == 0, $urandom % 50 == 0,
           $urandom % 10 != 0, $urandom % 4 != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
